// File: rtl/rom_viewer_pkg.sv
// Shared constants and types for the ROM viewer: button polarity, LED layout,
// default timing and the address-step encoding.
package rom_viewer_pkg;

  localparam logic        BTN_ACTIVE   = 1'b0;
  localparam logic        BTN_RELEASED = 1'b1;
  localparam int unsigned LED_AUTO     = 7;
  localparam int unsigned LED_W        = 8;
  localparam int unsigned SEG_W        = 9;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 240000;
  localparam int unsigned DEFAULT_AUTO_PERIOD     = 12000000;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, hold-time debouncer and a one-cycle
// press pulse on each accepted press (release is silent).
module btn_debounce
  import rom_viewer_pkg::*;
#(
  parameter int unsigned CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(CYCLES);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             dly_q;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = (dly_q != BTN_ACTIVE) && (level_q == BTN_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= BTN_RELEASED;
      sync2_q <= BTN_RELEASED;
      level_q <= BTN_RELEASED;
      dly_q   <= BTN_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      dly_q   <= level_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/segment.sv
// Hex digit to 7-segment decoder; output is {SEG,DP,G..A}, segments active-high.
module segment
  import rom_viewer_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg
);

  logic [6:0] gfedcba_c;

  always_comb begin
    gfedcba_c = 7'h00;
    case (digit)
      4'h0: gfedcba_c = 7'h3F;
      4'h1: gfedcba_c = 7'h06;
      4'h2: gfedcba_c = 7'h5B;
      4'h3: gfedcba_c = 7'h4F;
      4'h4: gfedcba_c = 7'h66;
      4'h5: gfedcba_c = 7'h6D;
      4'h6: gfedcba_c = 7'h7D;
      4'h7: gfedcba_c = 7'h07;
      4'h8: gfedcba_c = 7'h7F;
      4'h9: gfedcba_c = 7'h6F;
      4'hA: gfedcba_c = 7'h77;
      4'hB: gfedcba_c = 7'h7C;
      4'hC: gfedcba_c = 7'h39;
      4'hD: gfedcba_c = 7'h5E;
      4'hE: gfedcba_c = 7'h79;
      4'hF: gfedcba_c = 7'h71;
      default: gfedcba_c = 7'h00;
    endcase
  end

  // Digit always enabled, decimal point off.
  assign seg = {1'b1, 1'b0, gfedcba_c};

endmodule

// File: rtl/rom_viewer.sv
// ROM inspection top: button/auto-scan address stepping, LED address display
// and a selectable ROM byte shown on two hex digits.
module rom_viewer
  import rom_viewer_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned AUTO_PERIOD     = DEFAULT_AUTO_PERIOD
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_mode,
  input  logic              btn_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [LED_W-1:0]  led,
  output logic [SEG_W-1:0]  seg1,
  output logic [SEG_W-1:0]  seg2
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned BSEL_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned PER_W  = $clog2(AUTO_PERIOD);

  logic next_ev, prev_ev, mode_ev, sel_ev;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .resetn(resetn), .btn_n(btn_next), .press(next_ev));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(clk), .resetn(resetn), .btn_n(btn_prev), .press(prev_ev));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .resetn(resetn), .btn_n(btn_mode), .press(mode_ev));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clk(clk), .resetn(resetn), .btn_n(btn_sel), .press(sel_ev));

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              auto_q, auto_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic [BSEL_W-1:0] bsel_q, bsel_d;
  logic [LED_W-1:0]  led_q, led_d;
  step_e             step;

  // Manual events override the auto tick and restart the scan period.
  always_comb begin
    step   = STEP_NONE;
    addr_d = addr_q;
    auto_d = auto_q;
    per_d  = per_q;
    bsel_d = bsel_q;

    if (auto_q) begin
      if (per_q == PER_W'(AUTO_PERIOD - 1)) begin
        per_d = '0;
        step  = STEP_INC;
      end else begin
        per_d = per_q + 1'b1;
      end
    end

    if (next_ev || prev_ev) begin
      per_d = '0;
      if (next_ev && prev_ev) begin
        step = STEP_NONE;
      end else if (next_ev) begin
        step = STEP_INC;
      end else begin
        step = STEP_DEC;
      end
    end

    if (mode_ev) begin
      auto_d = ~auto_q;
      per_d  = '0;
    end

    case (step)
      STEP_INC: addr_d = addr_q + 1'b1;
      STEP_DEC: addr_d = addr_q - 1'b1;
      default:  addr_d = addr_q;
    endcase

    if (sel_ev) begin
      bsel_d = (bsel_q == BSEL_W'(NBYTES - 1)) ? '0 : bsel_q + 1'b1;
    end

    led_d                 = '1;
    led_d[LED_AUTO]       = ~auto_d;
    led_d[LED_AUTO-1:0]   = ~7'(addr_d);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q <= '0;
      auto_q <= 1'b0;
      per_q  <= '0;
      bsel_q <= '0;
      led_q  <= '1;
    end else begin
      addr_q <= addr_d;
      auto_q <= auto_d;
      per_q  <= per_d;
      bsel_q <= bsel_d;
      led_q  <= led_d;
    end
  end

  assign rom_addr = addr_q;
  assign led      = led_q;

  logic [7:0] byte_c;

  always_comb begin
    byte_c = rom_q[7:0];
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (BSEL_W'(i) == bsel_q) begin
        byte_c = rom_q[8*i +: 8];
      end
    end
  end

  segment u_seg_lo (.digit(byte_c[3:0]), .seg(seg1));
  segment u_seg_hi (.digit(byte_c[7:4]), .seg(seg2));

endmodule

// File: tb/tb_rom_viewer.sv
// Directed bench for rom_viewer with a synchronous ROM model (word k = A0B0C0D0+k).
module tb_rom_viewer;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 3;
  localparam logic [31:0] ROM_BASE = 32'hA0B0C0D0;

  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;
  localparam int BTN_MODE = 2;
  localparam int BTN_SEL  = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic              btn_next, btn_prev, btn_mode, btn_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [7:0]        led;
  logic [8:0]        seg1, seg2;

  int n_cmp = 0;
  int n_err = 0;

  rom_viewer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(16)
  ) dut (
    .clk(clk), .resetn(resetn),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_mode(btn_mode), .btn_sel(btn_sel),
    .rom_addr(rom_addr), .rom_q(rom_q), .led(led), .seg1(seg1), .seg2(seg2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= ROM_BASE + 32'(rom_addr);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] seg_ref(input logic [3:0] nib);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return {1'b1, 1'b0, t[nib]};
  endfunction

  function automatic logic [7:0] led_ref(input logic au, input int a);
    return {~au, ~7'(a)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      BTN_NEXT: btn_next = v;
      BTN_PREV: btn_prev = v;
      BTN_MODE: btn_mode = v;
      default:  btn_sel  = v;
    endcase
  endtask

  task automatic press_btn(input int idx);
    set_btn(idx, 1'b0);
    cyc(20);
    set_btn(idx, 1'b1);
    cyc(20);
  endtask

  task automatic chk_seg(input string tag, input int a, input int b);
    logic [31:0] w;
    logic [7:0]  by;
    w  = ROM_BASE + 32'(a);
    by = 8'(w >> (8 * b));
    chk({tag, "_seg1"}, 32'(seg1), 32'(seg_ref(by[3:0])));
    chk({tag, "_seg2"}, 32'(seg2), 32'(seg_ref(by[7:4])));
  endtask

  task automatic wait_change(input int budget, output int n);
    logic [ADDR_W-1:0] a0;
    a0 = rom_addr;
    n  = 0;
    while (n < budget && rom_addr == a0) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int exp_addr;

  initial begin
    resetn = 1'b0;
    btn_next = 1'b1; btn_prev = 1'b1; btn_mode = 1'b1; btn_sel = 1'b1;
    @(negedge clk);
    cyc(3);
    chk("rst_led", 32'(led), 32'h0000_00FF);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    resetn = 1'b1;
    cyc(2);
    chk_seg("rst", 0, 0);

    // Press latency: address changes on the 8th edge after the raw press.
    btn_next = 1'b0;
    cyc(7);
    chk("lat_before", 32'(rom_addr), 32'd0);
    cyc(1);
    chk("lat_after", 32'(rom_addr), 32'd1);
    cyc(12);
    btn_next = 1'b1;
    cyc(20);
    press_btn(BTN_NEXT);
    press_btn(BTN_NEXT);
    chk("next3_addr", 32'(rom_addr), 32'd3);
    chk("next3_led", 32'(led), 32'h0000_00FC);
    chk_seg("next3", 3, 0);

    btn_next = 1'b0;
    cyc(2);
    btn_next = 1'b1;
    cyc(20);
    chk("glitch", 32'(rom_addr), 32'd3);

    for (int i = 0; i < 5; i++) press_btn(BTN_NEXT);
    chk("wrap_up", 32'(rom_addr), 32'd0);
    press_btn(BTN_PREV);
    chk("wrap_down", 32'(rom_addr), 32'd7);
    chk("wrap_down_led", 32'(led), 32'(led_ref(1'b0, 7)));
    press_btn(BTN_NEXT);
    chk("back_to_0", 32'(rom_addr), 32'd0);
    btn_next = 1'b0; btn_prev = 1'b0;
    cyc(20);
    btn_next = 1'b1; btn_prev = 1'b1;
    cyc(20);
    chk("both", 32'(rom_addr), 32'd0);

    press_btn(BTN_NEXT);
    press_btn(BTN_NEXT);
    chk_seg("sel0", 2, 0);
    for (int b = 1; b <= 4; b++) begin
      press_btn(BTN_SEL);
      chk_seg($sformatf("sel%0d", b), 2, b % 4);
    end

    press_btn(BTN_PREV);
    press_btn(BTN_PREV);
    chk("pre_auto", 32'(rom_addr), 32'd0);

    // Auto on after edge 8; first tick 16 edges later (edge 24).
    btn_mode = 1'b0;
    cyc(20);
    btn_mode = 1'b1;
    chk("auto_led", 32'(led), 32'(led_ref(1'b1, 0)));
    wait_change(40, n);
    chk("auto_first", 32'(n), 32'd4);
    chk("auto_first_addr", 32'(rom_addr), 32'd1);
    exp_addr = 1;
    for (int s = 0; s < 8; s++) begin
      wait_change(40, n);
      exp_addr = (exp_addr + 1) % 8;
      chk($sformatf("auto_per%0d", s), 32'(n), 32'd16);
      chk($sformatf("auto_addr%0d", s), 32'(rom_addr), 32'(exp_addr));
    end

    cyc(4);
    btn_next = 1'b0;
    wait_change(40, n);
    exp_addr = (exp_addr + 1) % 8;
    chk("mid_manual_lat", 32'(n), 32'd8);
    chk("mid_manual_addr", 32'(rom_addr), 32'(exp_addr));
    btn_next = 1'b1;
    wait_change(40, n);
    exp_addr = (exp_addr + 1) % 8;
    chk("mid_restart", 32'(n), 32'd16);
    chk("mid_restart_addr", 32'(rom_addr), 32'(exp_addr));

    press_btn(BTN_SEL);

    // Reset during auto scan with next and mode part-way through debounce.
    btn_next = 1'b0; btn_mode = 1'b0;
    cyc(4);
    resetn = 1'b0;
    cyc(3);
    chk("rst2_led", 32'(led), 32'h0000_00FF);
    chk("rst2_addr", 32'(rom_addr), 32'd0);
    resetn = 1'b1;
    cyc(1);
    btn_next = 1'b1; btn_mode = 1'b1;
    cyc(40);
    chk("rst2_after_addr", 32'(rom_addr), 32'd0);
    chk("rst2_after_led", 32'(led), 32'h0000_00FF);
    chk_seg("rst2", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
